// File: rtl/axi4s_packet_arb.sv
// Packet-atomic round-robin arbiter that merges NUM_INPUTS AXI4-Stream sources onto one stream.
// Handshake: a beat transfers on a posedge with tvalid && tready. Once granted, an input owns the output until its tlast beat transfers.
module axi4s_packet_arb #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 32,
  parameter int USER_WIDTH = $clog2(WIDTH/8+1),
  parameter int SRC_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            en_mask,
  input  logic [NUM_INPUTS*WIDTH-1:0]      i_tdata,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0] i_tuser,
  input  logic [NUM_INPUTS-1:0]            i_tlast,
  input  logic [NUM_INPUTS-1:0]            i_tvalid,
  output logic [NUM_INPUTS-1:0]            i_tready,
  output logic [WIDTH-1:0]                 o_tdata,
  output logic [USER_WIDTH-1:0]            o_tuser,
  output logic                             o_tlast,
  output logic                             o_tvalid,
  input  logic                             o_tready,
  output logic [SRC_W-1:0]                 o_src,
  output logic                             busy
);

  localparam int PAD_W = 1 << SRC_W;
  localparam int SUM_W = SRC_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [SRC_W-1:0] grant, grant_next;
  logic [SRC_W-1:0] ptr, ptr_next;
  logic [SRC_W-1:0] pick;
  logic [PAD_W-1:0] req_pad;
  logic [SUM_W-1:0] idx;
  logic             sel_valid;
  logic             eop;

  // Scan downward so the last hit written is the first set bit at or after ptr.
  always_comb begin : rr_search
    req_pad = PAD_W'(i_tvalid & en_mask);
    pick    = '0;
    idx     = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + SUM_W'(k);
      if (idx >= SUM_W'(NUM_INPUTS)) begin
        idx = idx - SUM_W'(NUM_INPUTS);
      end
      if (req_pad[idx[SRC_W-1:0]]) begin
        pick = idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin : out_mux
    o_tdata   = i_tdata[0 +: WIDTH];
    o_tuser   = i_tuser[0 +: USER_WIDTH];
    o_tlast   = i_tlast[0];
    sel_valid = i_tvalid[0];
    i_tready  = '0;
    for (int n = 0; n < NUM_INPUTS; n++) begin
      if (grant == SRC_W'(n)) begin
        o_tdata     = i_tdata[n*WIDTH +: WIDTH];
        o_tuser     = i_tuser[n*USER_WIDTH +: USER_WIDTH];
        o_tlast     = i_tlast[n];
        sel_valid   = i_tvalid[n];
        i_tready[n] = (state == PASS) && o_tready;
      end
    end
    o_tvalid = (state == PASS) && sel_valid;
  end

  assign eop = o_tvalid && o_tready && o_tlast;

  always_comb begin : next_state
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (req_pad != '0) begin
          grant_next = pick;
          state_next = PASS;
        end
      end
      PASS: begin
        if (eop) begin
          state_next = IDLE;
          ptr_next   = (grant == SRC_W'(NUM_INPUTS - 1)) ? '0 : grant + SRC_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  assign o_src = grant;
  assign busy  = (state == PASS);

endmodule

// File: tb/tb_axi4s_packet_arb.sv
// Randomized bench for axi4s_packet_arb: per-source expected queues, a round-robin reference model and a decoupled monitor.
module tb_axi4s_packet_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int UW = 3;
  localparam int SW = 2;
  localparam int BW = 1 + UW + W;
  localparam int N3 = 3;

  logic            clk, reset;
  logic [N-1:0]    en_mask;
  logic [N*W-1:0]  i_tdata;
  logic [N*UW-1:0] i_tuser;
  logic [N-1:0]    i_tlast, i_tvalid, i_tready;
  logic [W-1:0]    o_tdata;
  logic [UW-1:0]   o_tuser;
  logic            o_tlast, o_tvalid, o_tready;
  logic [SW-1:0]   o_src;
  logic            busy;

  logic [W-1:0]  sd[N];
  logic [UW-1:0] su[N];
  logic          sl[N];
  logic          sv[N];
  logic [7:0]    ramp[N];

  logic [N3*W-1:0]  t3_data;
  logic [N3*UW-1:0] t3_user;
  logic [N3-1:0]    t3_last, t3_valid, t3_ready;
  logic [N3-1:0]    en_mask3;
  logic [W-1:0]     o3_data;
  logic [UW-1:0]    o3_user;
  logic             o3_last, o3_valid, o3_tready;
  logic [1:0]       o3_src;
  logic             o3_busy;
  logic [W-1:0]     d3[N3];
  logic             v3[N3];

  logic [BW-1:0] exp_q[N][$];
  int            grant_log[$];
  int            exp_log[$];
  int            pkt_cnt[N];
  int            n_tests, n_fail;
  logic          rdy_rand;

  always_comb begin
    i_tdata  = '0;
    i_tuser  = '0;
    i_tlast  = '0;
    i_tvalid = '0;
    for (int n = 0; n < N; n++) begin
      i_tdata[n*W +: W]   = sd[n];
      i_tuser[n*UW +: UW] = su[n];
      i_tlast[n]          = sl[n];
      i_tvalid[n]         = sv[n];
    end
  end

  always_comb begin
    t3_data  = '0;
    t3_user  = '0;
    t3_last  = '0;
    t3_valid = '0;
    for (int n = 0; n < N3; n++) begin
      t3_data[n*W +: W]   = d3[n];
      t3_user[n*UW +: UW] = UW'(n + 4);
      t3_last[n]          = 1'b1;
      t3_valid[n]         = v3[n];
    end
  end

  axi4s_packet_arb #(.NUM_INPUTS(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en_mask(en_mask),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
    .o_tvalid(o_tvalid), .o_tready(o_tready), .o_src(o_src), .busy(busy)
  );

  axi4s_packet_arb #(.NUM_INPUTS(N3), .WIDTH(W)) u3 (
    .clk(clk), .reset(reset), .en_mask(en_mask3),
    .i_tdata(t3_data), .i_tuser(t3_user), .i_tlast(t3_last),
    .i_tvalid(t3_valid), .i_tready(t3_ready),
    .o_tdata(o3_data), .o_tuser(o3_user), .o_tlast(o3_last),
    .o_tvalid(o3_valid), .o_tready(o3_tready), .o_src(o3_src), .busy(o3_busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < N; s++) sv[s] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout, expected event within budget (t=%0t)", name, $time);
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, 64'(grant_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < grant_log.size(); i++)
      check(name, 64'(grant_log[i]), 64'(exp_log[i]));
  endtask

  task automatic check_drained(input string name);
    for (int s = 0; s < N; s++) check(name, 64'(exp_q[s].size()), 64'd0);
  endtask

  // First requesting input at or after ptr, wrapping modulo N.
  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  // ---------------- driver ----------------
  task automatic run_src(input int s, input int npk, input int min_len, input int max_len,
                         input int stall_pct, input int last_user);
    logic [BW-1:0] pkt[$];
    logic [W-1:0]  d;
    logic [UW-1:0] u;
    int            len, to;
    for (int p = 0; p < npk; p++) begin
      len = $urandom_range(max_len, min_len);
      pkt.delete();
      for (int b = 0; b < len; b++) begin
        d = {ramp[s] + 8'd3, ramp[s] + 8'd2, ramp[s] + 8'd1, ramp[s]};
        ramp[s] = ramp[s] + 8'd4;
        u = UW'($urandom_range(7));
        if (b == len - 1 && last_user >= 0) u = UW'(last_user);
        pkt.push_back({(b == len - 1), u, d});
        exp_q[s].push_back({(b == len - 1), u, d});
      end
      for (int b = 0; b < len; b++) begin
        while (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
          @(negedge clk);
          sv[s] = 1'b0;
        end
        @(negedge clk);
        {sl[s], su[s], sd[s]} = pkt[b];
        sv[s] = 1'b1;
        to = 0;
        forever begin
          #4;
          if (i_tready[s]) break;
          to++;
          if (to > 3000) begin
            fail("src_handshake");
            break;
          end
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    sv[s] = 1'b0;
  endtask

  initial begin
    o_tready = 1'b1;
    forever begin
      @(negedge clk);
      o_tready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          m_busy;
    int            m_grant, m_ptr;
    logic [N-1:0]  req;
    logic [BW-1:0] e;
    m_busy  = 1'b0;
    m_grant = 0;
    m_ptr   = 0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        m_busy = 1'b0;
        m_ptr  = 0;
        for (int s = 0; s < N; s++) exp_q[s].delete();
      end else if (!m_busy) begin
        check("idle_tvalid", 64'(o_tvalid), 64'd0);
        check("idle_tready", 64'(i_tready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        for (int s = 0; s < N; s++) req[s] = sv[s] & en_mask[s];
        if (req != '0) begin
          m_grant = rr_pick(req, m_ptr);
          m_busy  = 1'b1;
        end
      end else begin
        check("pass_busy", 64'(busy), 64'd1);
        check("o_src", 64'(o_src), 64'(m_grant));
        check("i_tready", 64'(i_tready), o_tready ? (64'd1 << m_grant) : 64'd0);
        check("o_tvalid", 64'(o_tvalid), 64'(sv[m_grant]));
        if (sv[m_grant] && o_tready) begin
          if (exp_q[m_grant].size() == 0) begin
            fail("beat_expected");
          end else begin
            e = exp_q[m_grant].pop_front();
            check("beat", 64'({o_tlast, o_tuser, o_tdata}), 64'(e));
            if (e[BW-1]) begin
              grant_log.push_back(m_grant);
              pkt_cnt[m_grant]++;
              m_busy = 1'b0;
              m_ptr  = (m_grant + 1) % N;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int            to, b;
    logic [BW-1:0] beats[8];
    n_tests  = 0;
    n_fail   = 0;
    rdy_rand = 1'b0;
    en_mask  = '1;
    en_mask3 = '1;
    o3_tready = 1'b1;
    for (int s = 0; s < N; s++) begin
      sd[s] = '0; su[s] = '0; sl[s] = 1'b0; sv[s] = 1'b1;
      ramp[s] = 8'(s * 64);
      pkt_cnt[s] = 0;
    end
    for (int s = 0; s < N3; s++) begin
      d3[s] = '0; v3[s] = 1'b0;
    end
    reset = 1'b1;

    // reset values, with every input valid
    repeat (2) @(negedge clk);
    #4;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tready", 64'(i_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_src", 64'(o_src), 64'd0);
    @(negedge clk);
    for (int s = 0; s < N; s++) sv[s] = 1'b0;
    reset = 1'b0;
    idle(2);

    // single source, 5 beats, last tuser = 3
    grant_log.delete();
    run_src(2, 1, 5, 5, 0, 3);
    idle(3);
    exp_log = '{2};
    check_log("single");
    check_drained("single_drained");

    // fairness: all inputs continuously valid
    do_reset();
    grant_log.delete();
    fork
      run_src(0, 3, 1, 4, 0, -1);
      run_src(1, 3, 1, 4, 0, -1);
      run_src(2, 3, 1, 4, 0, -1);
      run_src(3, 3, 1, 4, 0, -1);
    join
    idle(3);
    exp_log = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    check_log("fair");
    check_drained("fair_drained");

    // mask 1010, clear bit 1 during the second packet of input 1
    do_reset();
    en_mask = 4'b1010;
    grant_log.delete();
    for (int s = 0; s < N; s++) pkt_cnt[s] = 0;
    fork
      run_src(0, 1, 2, 2, 0, -1);
      run_src(1, 2, 6, 6, 0, -1);
      run_src(2, 1, 2, 2, 0, -1);
      run_src(3, 2, 1, 4, 0, -1);
      begin
        to = 0;
        while (!(pkt_cnt[1] == 1 && busy && o_src == 2'd1) && to < 2000) begin
          @(negedge clk); #4; to++;
        end
        if (to >= 2000) fail("mask_second_grant");
        @(negedge clk);
        en_mask = 4'b1000;
        to = 0;
        while (!(pkt_cnt[1] == 2 && pkt_cnt[3] == 2) && to < 2000) begin
          @(negedge clk); #4; to++;
        end
        if (to >= 2000) fail("mask_drain");
        @(negedge clk);
        en_mask = 4'b1111;
      end
    join
    idle(3);
    exp_log = '{1, 3, 1, 3, 0, 2};
    check_log("mask");
    check_drained("mask_drained");

    // random backpressure and upstream stalls, 100 packets
    do_reset();
    grant_log.delete();
    rdy_rand = 1'b1;
    fork
      run_src(0, 25, 1, 8, 30, -1);
      run_src(1, 25, 1, 8, 30, -1);
      run_src(2, 25, 1, 8, 30, -1);
      run_src(3, 25, 1, 8, 30, -1);
    join
    rdy_rand = 1'b0;
    idle(4);
    check("bp_packets", 64'(grant_log.size()), 64'd100);
    check_drained("bp_drained");

    // reset on beat 3 of an 8-beat packet from input 2 while ptr points at 2
    do_reset();
    run_src(1, 1, 2, 2, 0, -1);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      beats[i] = {(i == 7), UW'(i), 32'hA5A5_0000 + 32'(i)};
      exp_q[2].push_back(beats[i]);
    end
    b = 0;
    to = 0;
    @(negedge clk);
    {sl[2], su[2], sd[2]} = beats[0];
    sv[2] = 1'b1;
    while (b < 2 && to < 50) begin
      #4;
      if (i_tready[2]) b++;
      @(negedge clk);
      {sl[2], su[2], sd[2]} = beats[b];
      to++;
    end
    if (to >= 50) fail("rst_mid_beats");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sv[2] = 1'b0;
    #4;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_tvalid", 64'(o_tvalid), 64'd0);
    grant_log.delete();
    fork
      run_src(0, 1, 1, 1, 0, -1);
      run_src(1, 1, 1, 1, 0, -1);
      run_src(2, 1, 1, 1, 0, -1);
      run_src(3, 1, 1, 1, 0, -1);
    join
    idle(3);
    exp_log = '{0, 1, 2, 3};
    check_log("rst_mid");
    check_drained("rst_mid_drained");

    // three-input instance: ptr=1 with inputs 0 and 2 valid
    do_reset();
    @(negedge clk);
    d3[0] = 32'h1111_0000; v3[0] = 1'b1;
    #4;
    check("n3_idle0", 64'(o3_busy), 64'd0);
    @(negedge clk);
    #4;
    check("n3_first_src", 64'(o3_src), 64'd0);
    check("n3_first_valid", 64'(o3_valid), 64'd1);
    @(negedge clk);
    d3[0] = 32'h2222_0000;
    d3[2] = 32'h3333_0002; v3[2] = 1'b1;
    #4;
    check("n3_gap_valid", 64'(o3_valid), 64'd0);
    @(negedge clk);
    #4;
    check("n3_wrap_src2", 64'(o3_src), 64'd2);
    check("n3_wrap_data2", 64'(o3_data), 64'h3333_0002);
    check("n3_wrap_user2", 64'(o3_user), 64'd6);
    check("n3_wrap_ready2", 64'(t3_ready), 64'b100);
    @(negedge clk);
    v3[2] = 1'b0;
    #4;
    check("n3_gap2_busy", 64'(o3_busy), 64'd0);
    @(negedge clk);
    #4;
    check("n3_wrap_src0", 64'(o3_src), 64'd0);
    check("n3_wrap_data0", 64'(o3_data), 64'h2222_0000);
    check("n3_wrap_last0", 64'(o3_last), 64'd1);
    @(negedge clk);
    v3[0] = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
